// File: rtl/parcnn_pkg.sv
// Shared definitions for the convolution reduction path.
//   DATA_W   : operand / sum width
//   clog2    : elaboration-time ceil(log2(n))
//   tag_t    : requester tag carried alongside the adder tree pipeline
package parcnn_pkg;
  localparam int DATA_W = 32;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int NUM_REQ_DFLT = 4;
  localparam int TAG_ID_W     = clog2(NUM_REQ_DFLT);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal priority pointer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req          : per-requester request
//   advance      : a grant was accepted this cycle; move pointer past winner
//   grant        : one-hot grant (combinational)
//   grant_idx    : binary index of the granted requester (0 when none)
module rr_arbiter
  import parcnn_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr;

  // Walk the search order backwards so the candidate closest to ptr is
  // written last and therefore wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
        grant                                        = '0;
        grant[ID_W'((int'(ptr) + k) % NUM_REQ)]      = 1'b1;
        grant_idx                                    = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      ptr <= '0;
    else if (advance)
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined adder tree between NUM_REQ requesters.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req_valid    : per-requester vector valid
//   req_data     : requester i at [i*TREE_SIZE*32 +: TREE_SIZE*32]
//   req_ready    : one-hot grant; transfer on valid & ready
//   tree_in      : operand vector to the tree (zero when idle)
//   tree_out     : tree sum, TREE_LATENCY cycles after tree_in
//   res_valid    : result strobe, res_id : owner, res_data : sum
//   busy         : request pending or result in flight
//   issue_count  : accepted vectors since reset (wraps)
module adder_tree_arbiter
  import parcnn_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TREE_SIZE    = 8,
  parameter int TREE_LATENCY = 3,
  parameter int ID_W         = TAG_ID_W
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*TREE_SIZE*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [TREE_SIZE*32-1:0]          tree_in,
  input  logic [31:0]                      tree_out,
  output logic                             res_valid,
  output logic [ID_W-1:0]                  res_id,
  output logic [31:0]                      res_data,
  output logic                             busy,
  output logic [31:0]                      issue_count
);

  localparam int VEC_W = TREE_SIZE * DATA_W;

  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_any;
  // Stage k holds the tag of the vector issued k cycles ago, so the last
  // stage lines up with tree_out.
  tag_t [TREE_LATENCY:1]   tag_pipe;
  logic [TREE_LATENCY:1]   vld_pipe;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .advance   (grant_any),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The arbiter only grants valid requesters, so any ready bit is a transfer.
  assign req_ready = reset ? '0 : grant;
  assign grant_any = |req_ready;

  always_comb begin
    tree_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) tree_in = req_data[i*VEC_W +: VEC_W];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= '{valid: grant_any, id: grant_idx};
      for (int k = 2; k <= TREE_LATENCY; k++)
        tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      issue_count <= '0;
    else if (grant_any)
      issue_count <= issue_count + 32'd1;
  end

  for (genvar k = 1; k <= TREE_LATENCY; k++) begin : g_vld
    assign vld_pipe[k] = tag_pipe[k].valid;
  end

  assign res_valid = tag_pipe[TREE_LATENCY].valid;
  assign res_id    = tag_pipe[TREE_LATENCY].id;
  assign res_data  = tree_out;
  assign busy      = (|req_valid) | (|vld_pipe);

endmodule

// File: tb/tb_adder_tree_arbiter.sv
module tb_adder_tree_arbiter;
  logic           clock;
  logic           reset;
  logic [3:0]     req_valid;
  logic [1023:0]  req_data;
  logic [3:0]     req_ready;
  logic [255:0]   tree_in;
  logic [31:0]    tree_out;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [31:0]    res_data;
  logic           busy;
  logic [31:0]    issue_count;

  adder_tree_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tree_in     (tree_in),
    .tree_out    (tree_out),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_data    (res_data),
    .busy        (busy),
    .issue_count (issue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the external 3-stage adder tree.
  logic [31:0] s1, s2, s3;
  always_ff @(posedge clock) begin
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc + tree_in[i*32 +: 32];
    s1 <= acc;
    s2 <= s1;
    s3 <= s2;
  end
  assign tree_out = s3;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] sum;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the result port against the expected queue.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_data", res_data, q[0].sum);
      void'(q.pop_front());
    end else begin
      chk("res_idle", 32'(res_valid), 32'd0);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] gnt,
                       input logic [1:0] id, input logic [31:0] s);
    req_valid = v;
    #1;
    chk("req_ready", 32'(req_ready), 32'(gnt));
    if (gnt != 4'd0) q.push_back('{cyc + 3, id, s});
    tick();
  endtask

  task automatic set_req(input int i, input logic [255:0] ops);
    req_data[i*256 +: 256] = ops;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, 2'd0, 32'd0);
  endtask

  logic [31:0] sums [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    set_req(0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});          // 36
    set_req(1, {32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd1, 32'd0});    // 61
    set_req(2, {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd26});         // 33
    set_req(3, {32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});        // 100
    sums[0] = 32'd36; sums[1] = 32'd61; sums[2] = 32'd33; sums[3] = 32'd100;

    // Reset state; ready held low while reset is asserted.
    tick();
    req_valid = 4'b0001;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("rst_tree_in", 32'(|tree_in), 32'd0);

    // Single requester.
    drive(4'b0001, 4'b0001, 2'd0, 32'd36);
    chk("single_count", issue_count, 32'd1);
    idle(3);
    chk("single_busy", 32'(busy), 32'd0);

    // Fairness: all valid from pointer 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++)
      drive(4'b1111, 4'(1 << (k % 4)), 2'(k % 4), sums[k % 4]);
    req_valid = 4'b0000;
    #1;
    chk("fair_busy_inflight", 32'(busy), 32'd1);
    idle(3);
    chk("fair_count", issue_count, 32'd6);

    // Sparse: req 2 at p=0, then {1,3} from p=3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(4'b0100, 4'b0100, 2'd2, 32'd33);
    drive(4'b1010, 4'b1000, 2'd3, 32'd100);
    drive(4'b0010, 4'b0010, 2'd1, 32'd61);
    idle(3);
    chk("sparse_count", issue_count, 32'd3);

    // Hold and drop from p=2: req 1 loses twice, req 0 withdraws ungranted.
    set_req(1, {8{32'd5}});                                                        // 40
    drive(4'b1111, 4'b0100, 2'd2, 32'd33);
    drive(4'b1010, 4'b1000, 2'd3, 32'd100);
    drive(4'b0010, 4'b0010, 2'd1, 32'd40);
    idle(3);
    chk("hold_count", issue_count, 32'd6);

    // Reset mid-flight: the first result lands in the reset cycle, the
    // other two must never appear.
    drive(4'b0001, 4'b0001, 2'd0, 32'd36);
    drive(4'b0010, 4'b0010, 2'd1, 32'd40);
    drive(4'b0100, 4'b0100, 2'd2, 32'd33);
    reset = 1'b1;
    req_valid = 4'b0001;
    q.delete();
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("mid_count", issue_count, 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    idle(3);
    drive(4'b1111, 4'b0001, 2'd0, 32'd36);
    idle(3);

    // Wrap of both the sum and the issue counter.
    set_req(0, {32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
    force dut.issue_count = 32'hFFFF_FFFF;
    #1;
    release dut.issue_count;
    drive(4'b0001, 4'b0001, 2'd0, 32'd0);
    chk("wrap_count", issue_count, 32'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder_tree_arbiter.md
Name: adder_tree_arbiter

Overview:
Shares one pipelined adder_tree_32bit instance between NUM_REQ requesters.
- Each requester offers one TREE_SIZE-operand vector with a valid/ready handshake.
- A round-robin arbiter issues at most one vector per cycle into the tree.
- An ID tag travels through a shift pipeline matched to the tree depth, so every sum returns with its requester ID.
- The block sits between the convolution window generators and the shared reduction tree.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- TREE_SIZE, 8, operands per vector; passed to the tree.
- TREE_LATENCY, 3, register depth of the tree (log2(TREE_SIZE)); depth of the tag pipeline.
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*TREE_SIZE*32  requester i occupies slice [i*TREE_SIZE*32 +: TREE_SIZE*32].
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid&ready.
- tree_in  out  TREE_SIZE*32  operand vector driven to the tree.
- tree_out  in  32  tree sum.
- res_valid  out  1  result strobe.
- res_id  out  ID_W  requester that owns res_data.
- res_data  out  32  sum, equal to tree_out while res_valid.
- busy  out  1  any issue in flight or any req_valid high.
- issue_count  out  32  total accepted vectors since reset; wraps modulo 2^32.

Behaviour:
- Clock and reset: single clock. Reset is synchronous, active-high, sampled on the rising edge of clock.
- Reset values: req_ready=0, res_valid=0, res_id=0, busy=0, issue_count=0, rr pointer=0, tag pipeline all-invalid. res_data follows tree_out but is ignored when res_valid=0.
- Arbitration (combinational, cycle t):
  - Search starts at pointer p and runs p, p+1, …, NUM_REQ-1, 0, …, p-1.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. At most one bit is set.
  - No valid request: req_ready=0.
  - req_ready is 0 throughout any cycle in which reset=1.
- Pointer update: on an accepted transfer from i, p <= (i+1) mod NUM_REQ. With no transfer, p holds.
- Operand mux: tree_in = granted requester's slice in cycle t. With no grant, tree_in = all-zero.
- Tag pipeline:
  - Stage 0 captures {valid=grant_any, id=i} at the end of cycle t. The tag shifts one stage per cycle with no stalls.
  - res_valid=1 and res_id=i during cycle t+TREE_LATENCY, aligned with the tree_out for that vector.
  - Issue-to-result latency is exactly TREE_LATENCY cycles.
  - Throughput is 1 vector/cycle. Up to TREE_LATENCY results are in flight.
- No result backpressure: a consumer must accept res_valid every cycle.
- Requester rules:
  - A requester holds req_data stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before grant is permitted.
- Arithmetic: sums wrap modulo 2^32 inside the tree. The block passes tree_out unchanged.
- issue_count increments by 1 per accepted transfer.
- Simultaneous events: reset coinciding with a valid request means no transfer, no count, and the pointer goes to 0.
- Reset mid-operation: all in-flight tags are cleared at that edge. res_valid is 0 from the next cycle onward, and those sums are discarded (never reported). The tree's own registers need not be cleared, because untagged outputs are ignored.
- busy = |req_valid OR any tag-pipeline valid bit.

Decomposition:
- Shared package parcnn_pkg holds:
  - DATA_W=32.
  - A function clog2 used for ID_W.
  - Typedef tag_t {logic valid; logic [ID_W-1:0] id}.
- Sub-module rr_arbiter (NUM_REQ): inputs req, advance; output one-hot grant and granted index. It holds the pointer internally.
- adder_tree_arbiter instantiates rr_arbiter plus the tag shift pipeline. The adder tree is instantiated at the level above.

Test Plan:
- Single requester: req 0 valid with {1,2,3,4,5,6,7,8}, tree model attached. Required: req_ready[0] in the same cycle, and res_valid with res_id=0, res_data=36 exactly 3 cycles later. issue_count=1.
- Fairness: all 4 requesters continuously valid. Required: grant order 0,1,2,3,0,1. Results {36,61,33,…} return in issue order with matching res_id, one per cycle, no bubbles.
- Sparse requests: req 2 valid while p=0. Required: grant 2 and pointer moves to 3. Then req 1 and req 3 valid together. Required: grant 3, then 1.
- Hold and drop: req 1 valid but losing for 2 cycles, data held. Required: granted on its turn with the correct sum. A request withdrawn before grant produces no result and no count.
- Reset mid-flight: issue 3 vectors, assert reset on the cycle after the last issue. Required: no res_valid afterwards, and issue_count, pointer and busy all return to 0.
- Wrap: operands {32'hFFFFFFFF,1,0,…} with issue_count preloaded near 2^32-1 via 2^32-1 transfers (or forced). Required: res_data=0 and issue_count wraps to 0.
